load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte address width on CPU and cache sides.
REQ-002 SHALL have port: clock  in  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: mem_read  in  1  CPU load request, held until stall low.
REQ-005 SHALL have port: mem_write  in  1  CPU store request, held until stall low.
REQ-006 SHALL have port: funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port: address  in  ADDR_W  CPU byte address.
REQ-008 SHALL have port: store_data  in  32  store operand; the low byte/half is used for SB/SH.
REQ-009 SHALL have port: load_data  out  32  registered, aligned and extended load result.
REQ-010 SHALL have port: stall  out  1  CPU stall.
REQ-011 SHALL have port: misaligned  out  1  one-cycle misalignment pulse (feature in REQ-033).
REQ-012 SHALL have ports to the data cache: dc_read out 1; dc_write out 1; dc_address out ADDR_W; dc_writedata out 32; dc_readdata in 32; dc_busywait in 1.

Function
REQ-013 SHALL accept a request in IDLE and latch address, funct3 and store_data, so cache-side outputs come only from latched values.
REQ-014 SHALL drive dc_address as {latched address[ADDR_W-1:2], 2'b00} in every non-IDLE state.
REQ-015 SHALL use states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT and DONE.
REQ-016 From IDLE: load -> RD_ISSUE; SW -> WR_ISSUE; SB/SH -> RD_ISSUE (read-modify-write).
REQ-017 SHALL assert dc_read in RD_ISSUE and RD_WAIT; ISSUE always advances to its WAIT state after 1 cycle.
REQ-018 In RD_WAIT with dc_busywait=0: capture dc_readdata; a load goes to DONE, SB/SH goes to WR_ISSUE.
REQ-019 SHALL assert dc_write in WR_ISSUE and WR_WAIT; WR_WAIT with dc_busywait=0 goes to DONE.
REQ-020 dc_writedata for SW SHALL be store_data; for SB/SH it SHALL be the captured word with only the addressed byte (address[1:0]) or half (address[1]) replaced.
REQ-021 SHALL register load_data in RD_WAIT completion: LB/LH sign-extended, LBU/LHU zero-extended, selected by address[1:0].
REQ-022 stall SHALL be 1 in IDLE with a request present and in every state except DONE; stall SHALL be 0 in DONE and in IDLE without a request.
REQ-023 DONE SHALL last exactly 1 cycle and then return to IDLE; the CPU advances on that edge.
REQ-024 Latency on a cache hit: load 3 cycles, SW 3 cycles, SB/SH 5 cycles from request to the end of the DONE cycle.
REQ-025 Simultaneous mem_read and mem_write SHALL be executed as a store.
REQ-026 funct3 011/110/111 SHALL be executed as a word access.
REQ-027 dc_read and dc_write SHALL never be 1 in the same cycle.

Reset
REQ-028 While reset=0: state=IDLE; dc_read=0, dc_write=0, load_data=0, misaligned=0, dc_writedata=0, dc_address=0, regardless of the clock.
REQ-029 Reset during any state SHALL abandon the transaction; after release the CPU re-presents its request.

Configuration
REQ-030 With MISALIGN_TRAP_EN defined: H/HU with address[0]=1, or W with address[1:0]!=0, is detected in IDLE.
REQ-031 With MISALIGN_TRAP_EN defined, a misaligned request SHALL go directly to DONE with misaligned=1 and load_data=0, and SHALL issue no cache access.
REQ-032 Without MISALIGN_TRAP_EN: misaligned is tied 0; the low address bits are ignored (H uses address[1], W ignores both bits).
REQ-033 The misaligned port SHALL exist in both configurations.

Structure
REQ-034 Package lsu_pkg SHALL hold the funct3 constants and the state encoding type.
REQ-035 Combinational sub-module lsu_align SHALL perform the load extract/extend and the store merge; the FSM and registers stay in load_store_unit.

Verification
REQ-036 LW at 0x100 with dc_readdata=0xDEADBEEF, busywait 0 -> load_data=0xDEADBEEF; DONE in cycle 3; stall low only in DONE.
REQ-037 LB at 0x103 with word 0x80FF7F01 -> 0xFFFFFF80; LBU -> 0x00000080; LHU at 0x102 -> 0x000080FF.
REQ-038 SB 0xAB at 0x201 with old word 0x11223344 -> one read, then one write with dc_writedata=0x1122AB44; read/write never overlap.
REQ-039 LW with dc_busywait held 1 for 20 cycles in RD_WAIT -> stall stays 1 throughout; completion 1 cycle after busywait falls.
REQ-040 Reset asserted in WR_WAIT -> dc_write=0 immediately and state=IDLE.
REQ-041 With MISALIGN_TRAP_EN, LW at 0x102 -> misaligned=1 for one cycle and no dc_read; without the macro -> word read at 0x100.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, access sizes and FSM state type for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_t;

    // Unused width codes (011/110/111) fall through to a word access.
    function automatic lsu_size_t size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load extract/extend and store byte/half merge
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        zero_ext;

    // Halves are selected by offset[1] only, so an odd half address behaves as the even one.
    always_comb begin
        byte_sel   = word[{offset, 3'b000} +: 8];
        half_sel   = word[{offset[1], 4'b0000} +: 16];
        zero_ext   = funct3[2];
        load_value = word;
        merged     = store_data;
        case (size_of(funct3))
            SZ_BYTE: begin
                load_value = zero_ext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merged = word;
                merged[{offset, 3'b000} +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_value = zero_ext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                merged = word;
                merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: begin
                load_value = word;
                merged     = store_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store to data-cache FSM with read-modify-write sub-word stores (option MISALIGN_TRAP_EN)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              misaligned,
    output logic              dc_read,
    output logic              dc_write,
    output logic [ADDR_W-1:0] dc_address,
    output logic [31:0]       dc_writedata,
    input  logic [31:0]       dc_readdata,
    input  logic              dc_busywait
);

    lsu_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       sdata_q;
    logic              store_q;
    logic              request;
    logic              mis_detect;
    logic [31:0]       load_value;
    logic [31:0]       merged;

    assign request = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
    // Flag halves on odd addresses and words off a 4-byte boundary before any cache access.
    always_comb begin
        case (size_of(funct3))
            SZ_HALF: mis_detect = address[0];
            SZ_WORD: mis_detect = |address[1:0];
            default: mis_detect = 1'b0;
        endcase
    end
`else
    assign mis_detect = 1'b0;
`endif

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .word       (dc_readdata),
        .store_data (sdata_q),
        .load_value (load_value),
        .merged     (merged)
    );

    assign dc_address = (state == IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};

    // Hold the CPU except in DONE and in IDLE when nothing is requested.
    always_comb begin
        stall = 1'b1;
        if (state == IDLE) begin
            stall = request;
        end else if (state == DONE) begin
            stall = 1'b0;
        end
    end

    // Transaction FSM; cache strobes and results are registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            f3_q         <= '0;
            sdata_q      <= '0;
            store_q      <= 1'b0;
            load_data    <= '0;
            misaligned   <= 1'b0;
            dc_read      <= 1'b0;
            dc_write     <= 1'b0;
            dc_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        addr_q  <= address;
                        f3_q    <= funct3;
                        sdata_q <= store_data;
                        store_q <= mem_write;
                        if (mis_detect) begin
                            state      <= DONE;
                            misaligned <= 1'b1;
                            load_data  <= '0;
                        end else if (mem_write && size_of(funct3) == SZ_WORD) begin
                            state        <= WR_ISSUE;
                            dc_write     <= 1'b1;
                            dc_writedata <= store_data;
                        end else begin
                            state   <= RD_ISSUE;
                            dc_read <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    if (!dc_busywait) begin
                        dc_read <= 1'b0;
                        if (store_q) begin
                            state        <= WR_ISSUE;
                            dc_write     <= 1'b1;
                            dc_writedata <= merged;
                        end else begin
                            state     <= DONE;
                            load_data <= load_value;
                        end
                    end
                end
                WR_ISSUE: state <= WR_WAIT;
                WR_WAIT: begin
                    if (!dc_busywait) begin
                        state    <= DONE;
                        dc_write <= 1'b0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    misaligned <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural cache and model
module tb_load_store_unit;

    localparam int CYC = 10;

    logic        clock;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic        dc_read;
    logic        dc_write;
    logic [31:0] dc_address;
    logic [31:0] dc_writedata;
    logic [31:0] dc_readdata;
    logic        dc_busywait;

    load_store_unit #(.ADDR_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .address      (address),
        .store_data   (store_data),
        .load_data    (load_data),
        .stall        (stall),
        .misaligned   (misaligned),
        .dc_read      (dc_read),
        .dc_write     (dc_write),
        .dc_address   (dc_address),
        .dc_writedata (dc_writedata),
        .dc_readdata  (dc_readdata),
        .dc_busywait  (dc_busywait)
    );

    initial clock = 1'b0;
    always #(CYC/2) clock = ~clock;

    // Behavioural cache: word array, busywait held for a programmed number of wait cycles.
    logic [31:0] mem [0:255];
    int          busy_rd;
    int          busy_wr;
    int          rd_seen;
    int          wr_seen;
    int          rd_done;
    int          wr_done;
    int          overlap_cnt;
    int          addr_err_cnt;
    logic        pre_req;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    assign dc_readdata = mem[dc_address[9:2]];
    assign dc_busywait = (dc_read  && busy_rd > 0 && rd_seen <= busy_rd) ||
                         (dc_write && busy_wr > 0 && wr_seen <= busy_wr);

    always @(posedge clock) begin
        rd_seen <= dc_read  ? rd_seen + 1 : 0;
        wr_seen <= dc_write ? wr_seen + 1 : 0;
        if (dc_read && dc_write) overlap_cnt <= overlap_cnt + 1;
        if ((dc_read || dc_write) && dc_address[1:0] != 2'b00) addr_err_cnt <= addr_err_cnt + 1;
        if (dc_read && !dc_busywait && rd_seen >= 1) rd_done <= rd_done + 1;
        if (pre_req) begin
            mem[pre_idx] <= pre_val;
        end else if (dc_write && !dc_busywait && wr_seen >= 1) begin
            mem[dc_address[9:2]] <= dc_writedata;
            wr_done <= wr_done + 1;
        end
    end

    initial begin
        rd_seen = 0; wr_seen = 0; rd_done = 0; wr_done = 0;
        overlap_cnt = 0; addr_err_cnt = 0;
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference rules: 0 byte, 1 half, 2 word.
    function automatic int f3_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 0;
        if (f3 == 3'b001 || f3 == 3'b101) return 1;
        return 2;
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
        bit m;
        m = 1'b0;
`ifdef MISALIGN_TRAP_EN
        m = (f3_size(f3) == 1 && a[0]) || (f3_size(f3) == 2 && a[1:0] != 2'b00);
`endif
        return m;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        if (f3_size(f3) == 0) begin
            v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
        end else if (f3_size(f3) == 1) begin
            v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        logic [31:0] mask;
        int          sh;
        if (f3_size(f3) == 2) return sd;
        mask = (f3_size(f3) == 0) ? 32'hFF : 32'hFFFF;
        sh   = (f3_size(f3) == 0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        return (w & ~(mask << sh)) | ((sd & mask) << sh);
    endfunction

    task automatic preset(input logic [31:0] a, input logic [31:0] v);
        pre_idx = a[9:2];
        pre_val = v;
        pre_req = 1'b1;
        @(posedge clock);
        #1;
        pre_req = 1'b0;
    endtask

    // Present one request, wait for DONE, and compare latency, result, traffic and memory.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] init,
                          input int brd, input int bwr, input logic [31:0] exp_load, input logic [31:0] exp_word);
        int lat, rd0, wr0, exp_lat, exp_rd, exp_wr;
        bit done, exp_mis;
        exp_mis = model_mis(f3, addr);
        if (exp_mis) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (wr) begin
            if (f3_size(f3) == 2) begin
                exp_lat = 3 + bwr; exp_rd = 0; exp_wr = 1;
            end else begin
                exp_lat = 5 + brd + bwr; exp_rd = 1; exp_wr = 1;
            end
        end else begin
            exp_lat = 3 + brd; exp_rd = 1; exp_wr = 0;
        end
        busy_rd = brd;
        busy_wr = bwr;
        preset(addr, init);
        rd0 = rd_done;
        wr0 = wr_done;
        mem_read = rd; mem_write = wr; funct3 = f3; address = addr; store_data = sd;
        lat = 0;
        done = 1'b0;
        while (!done && lat < 300) begin
            @(negedge clock);
            if (!stall) done = 1'b1;
            else begin
                @(posedge clock);
                lat++;
            end
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/misaligned"}, {31'h0, misaligned}, {31'h0, exp_mis});
        if (!wr || exp_mis) check({tag, "/load_data"}, load_data, exp_load);
        @(posedge clock);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clock);
        check({tag, "/idle_stall"}, {31'h0, stall}, 32'h0);
        check({tag, "/idle_misaligned"}, {31'h0, misaligned}, 32'h0);
        check({tag, "/reads"}, rd_done - rd0, exp_rd);
        check({tag, "/writes"}, wr_done - wr0, exp_wr);
        check({tag, "/mem_word"}, mem[addr[9:2]], exp_word);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] init;
        int          brd;
        int          bwr;
        logic [31:0] exp_load;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #(CYC * 40000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] ld_codes [8];
        logic [2:0] st_codes [6];
        bit         reached;

        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        st_codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF7F01, 0,  0, 32'hFFFFFF80, 32'h80FF7F01};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF7F01, 0,  0, 32'h00000080, 32'h80FF7F01};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80FF7F01, 0,  0, 32'h000080FF, 32'h80FF7F01};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF7F01, 0,  0, 32'hFFFF80FF, 32'h80FF7F01};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h80FF7F01, 0,  0, 32'h0000007F, 32'h80FF7F01};
        vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h80FF7F01, 0,  0, 32'h00007F01, 32'h80FF7F01};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'hFFFFFFAB, 32'h11223344, 0,  0, 32'h0,        32'h1122AB44};
        vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234BEEF, 32'h11223344, 0,  0, 32'h0,        32'hBEEF3344};
        vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h00000000, 0,  2, 32'h0,        32'hCAFEF00D};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 20, 0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h208, 32'h5A5A5A5A, 32'h00000000, 0,  0, 32'h0,        32'h5A5A5A5A};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h10C, 32'h0,        32'h13579BDF, 0,  0, 32'h13579BDF, 32'h13579BDF};
        vecs[13] = '{1'b0, 1'b1, 3'b000, 32'h20B, 32'h000000EE, 32'h11223344, 3,  2, 32'h0,        32'hEE223344};
`ifdef MISALIGN_TRAP_EN
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'hA5A5C3C3, 0,  0, 32'h0,        32'hA5A5C3C3};
        vecs[15] = '{1'b0, 1'b1, 3'b001, 32'h201, 32'h0000BEEF, 32'h11223344, 0,  0, 32'h0,        32'h11223344};
`else
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'hA5A5C3C3, 0,  0, 32'hA5A5C3C3, 32'hA5A5C3C3};
        vecs[15] = '{1'b0, 1'b1, 3'b001, 32'h201, 32'h0000BEEF, 32'h11223344, 0,  0, 32'h0,        32'h1122BEEF};
`endif

        reset = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        address = 32'h0; store_data = 32'h0;
        busy_rd = 0; busy_wr = 0;
        pre_req = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset/load_data", load_data, 32'h0);
        check("reset/dc_read", {31'h0, dc_read}, 32'h0);
        check("reset/dc_write", {31'h0, dc_write}, 32'h0);
        check("reset/dc_address", dc_address, 32'h0);
        check("reset/dc_writedata", dc_writedata, 32'h0);
        check("reset/misaligned", {31'h0, misaligned}, 32'h0);
        check("reset/stall", {31'h0, stall}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sd,
                   vecs[i].init, vecs[i].brd, vecs[i].bwr, vecs[i].exp_load, vecs[i].exp_word);
        end

        // Abort an SB while the write is stalled in WR_WAIT, then re-present it.
        busy_rd = 0;
        busy_wr = 50;
        preset(32'h300, 32'h11223344);
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b000; address = 32'h302; store_data = 32'h00000077;
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge clock);
            if (dc_write) reached = 1'b1;
        end
        check("rst_mid/reached_write", {31'h0, reached}, 32'h1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid/dc_write", {31'h0, dc_write}, 32'h0);
        check("rst_mid/dc_read", {31'h0, dc_read}, 32'h0);
        check("rst_mid/dc_address", dc_address, 32'h0);
        check("rst_mid/dc_writedata", dc_writedata, 32'h0);
        check("rst_mid/load_data", load_data, 32'h0);
        check("rst_mid/stall_idle_req", {31'h0, stall}, 32'h1);
        @(posedge clock);
        #1;
        check("rst_mid/dc_write_held", {31'h0, dc_write}, 32'h0);
        check("rst_mid/mem_untouched", mem[8'hC0], 32'h11223344);
        mem_write = 1'b0;
        busy_wr = 0;
        #2;
        reset = 1'b1;
        run_op("rst_mid/retry", 1'b0, 1'b1, 3'b000, 32'h302, 32'h00000077, 32'h11223344, 0, 0,
               32'h0, 32'h11773344);

        for (int i = 0; i < 40; i++) begin
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] a, sd, w, el, ew;
            int          brd, bwr;
            wr  = $urandom_range(0, 1) == 1;
            rd  = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
            f3  = wr ? st_codes[$urandom_range(0, 5)] : ld_codes[$urandom_range(0, 7)];
            a   = $urandom_range(0, 1023);
            sd  = $urandom;
            w   = $urandom;
            brd = $urandom_range(0, 3);
            bwr = $urandom_range(0, 3);
            if (model_mis(f3, a)) begin
                el = 32'h0;
                ew = w;
            end else begin
                el = model_load(w, f3, a);
                ew = wr ? model_store(w, f3, a, sd) : w;
            end
            run_op($sformatf("rand%0d", i), rd, wr, f3, a, sd, w, brd, bwr, el, ew);
        end

        check("global/read_write_overlap", overlap_cnt, 32'h0);
        check("global/dc_address_aligned", addr_err_cnt, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
